// File: rtl/multi_led_blinker_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam int BURST_W = 8;

  // Channel index width; never zero so a one-channel build still has a port.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_led_blinker_if.sv
// Single-cycle configuration write port shared by all LED channels.
interface multi_led_blinker_if
  import led_blink_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
);
  localparam int CH_W = ch_w(NUM_CH);

  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  mode_e              cfg_mode;
  logic [CNT_W-1:0]   cfg_half;
  logic [BURST_W-1:0] cfg_count;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count);
endinterface

// File: rtl/multi_led_blinker_channel.sv
// One LED channel: OFF / ON / BLINK / BURST pattern generator with registered outputs.
module led_channel
  import led_blink_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               we,
  input  mode_e              mode,
  input  logic [CNT_W-1:0]   half,
  input  logic [BURST_W-1:0] count,
  output logic               led,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_BLINK, ST_BURST} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               led_d, busy_d, done_d;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      half_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      led     <= led_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    led_d   = led;
    done_d  = 1'b0;

    if (we) begin
      // A write always restarts the pattern, silently abandoning any burst.
      half_d = half;
      cnt_d  = '0;
      rem_d  = count;
      unique case (mode)
        MODE_OFF:   begin state_d = ST_OFF;   led_d = 1'b0; end
        MODE_ON:    begin state_d = ST_ON;    led_d = 1'b1; end
        MODE_BLINK: begin state_d = ST_BLINK; led_d = 1'b1; end
        MODE_BURST: begin
          if (count == '0) begin
            state_d = ST_OFF;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_BURST;
            led_d   = 1'b1;
          end
        end
      endcase
    end else if (tick && (state_q == ST_BLINK || state_q == ST_BURST)) begin
      if (cnt_q == half_q) begin
        cnt_d = '0;
        led_d = ~led;
        // Falling edges count completed blinks; the last one ends the burst.
        if (state_q == ST_BURST && led) begin
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = ST_OFF;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == ST_BLINK) || (state_d == ST_BURST);
  end

endmodule

// File: rtl/multi_led_blinker.sv
// NUM_CH independent LED channels sharing one tick prescaler and one config write port.
module multi_led_blinker
  import led_blink_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 24,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  multi_led_blinker_if.slave cfg,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);
  localparam int CH_W = ch_w(NUM_CH);

  logic tick;

  generate
    if (TICK_DIV <= 1) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      localparam int PW = $clog2(TICK_DIV);
      logic [PW-1:0] pre;
      // Free-running; configuration writes never realign it.
      always_ff @(posedge clk) begin
        if (rst)                         pre <= '0;
        else if (pre == PW'(TICK_DIV-1)) pre <= '0;
        else                             pre <= pre + PW'(1);
      end
      assign tick = (pre == PW'(TICK_DIV-1));
    end
  endgenerate

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range indices match no channel, so such writes are dropped.
    led_channel #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .we    (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))),
      .mode  (cfg.cfg_mode),
      .half  (cfg.cfg_half),
      .count (cfg.cfg_count),
      .led   (led[i]),
      .busy  (busy[i]),
      .done  (done[i])
    );
  end

endmodule
